// File: rtl/alarm_scheduler_pkg.sv
// Shared definitions for the alarm scheduler: time-field widths, slice
// positions of the clockwork time bus and the alarm word, and FSM states.
package alarm_scheduler_pkg;

  localparam int HOUR_W  = 5;
  localparam int MIN_W   = 6;
  localparam int SEC_W   = 6;
  localparam int TIME_W  = HOUR_W + MIN_W + SEC_W;  // {hour,min,sec}
  localparam int ALARM_W = HOUR_W + MIN_W;          // {hour,min}
  localparam int SLOT_W  = ALARM_W + 1;             // {arm,hour,min}

  // Field positions inside the 17-bit time bus
  localparam int SEC_LSB  = 0;
  localparam int MIN_LSB  = SEC_W;
  localparam int HOUR_LSB = SEC_W + MIN_W;

  // Field positions inside the 11-bit alarm word
  localparam int AL_MIN_LSB  = 0;
  localparam int AL_HOUR_LSB = MIN_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_RING   = 2'd2,
    ST_SNOOZE = 2'd3
  } state_t;

  // Drop the seconds field to get the {hour,min} word compared against slots
  function automatic logic [ALARM_W-1:0] time_to_alarm(input logic [TIME_W-1:0] t);
    return t[TIME_W-1:MIN_LSB];
  endfunction

endpackage

// File: rtl/alarm_scheduler_if.sv
// Slot write port of the alarm scheduler.
// Handshake: wr_en is a one-clk strobe with no ready; the slot bank accepts a
// write on every clk in every state, and the new contents are visible on the
// following clk. Writes to an index >= SLOTS are dropped by the receiver.
interface alarm_scheduler_if #(
  parameter int SLOTS = 4
);
  localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  logic                                 wr_en;
  logic [IDX_W-1:0]                     wr_slot;
  logic [alarm_scheduler_pkg::ALARM_W-1:0] wr_time;
  logic                                 wr_arm;

  modport master (output wr_en, wr_slot, wr_time, wr_arm);
  modport slave  (input  wr_en, wr_slot, wr_time, wr_arm);
endinterface

// File: rtl/alarm_scheduler_slot_bank.sv
// Register file of alarm slots: {hour,min} plus armed bit per slot.
// One write port, one combinational read port, armed vector out.
module alarm_slot_bank
  import alarm_scheduler_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_slot,
  input  logic [ALARM_W-1:0] wr_time,
  input  logic               wr_arm,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [ALARM_W-1:0] rd_time,
  output logic               rd_arm,
  output logic [SLOTS-1:0]   armed
);

  logic [ALARM_W-1:0] slot_time [SLOTS];
  logic [SLOTS-1:0]   slot_arm;
  logic               wr_ok;

  // Out-of-range indices exist when SLOTS is not a power of two
  assign wr_ok = wr_en && (32'(wr_slot) < SLOTS);

  // Slot storage; reset disarms every slot at 00:00
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SLOTS; i++) slot_time[i] <= '0;
      slot_arm <= '0;
    end else if (wr_ok) begin
      slot_time[wr_slot] <= wr_time;
      slot_arm[wr_slot]  <= wr_arm;
    end
  end

  assign rd_time = slot_time[rd_idx];
  assign rd_arm  = slot_arm[rd_idx];
  assign armed   = slot_arm;

endmodule

// File: rtl/alarm_scheduler.sv
// Multi-slot alarm controller: detects each new minute on the clockwork bus,
// scans the slots one per clk through a shared comparator and runs a single
// ring session with snooze, dismiss and no-response timeout.
module alarm_scheduler
  import alarm_scheduler_pkg::*;
#(
  parameter int SLOTS      = 4,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3,
  parameter int RING_SEC   = 60,
  parameter int IDX_W      = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TIME_W-1:0] time_in,
  input  logic              tick,
  alarm_scheduler_if.slave  wr,
  input  logic              dismiss,
  input  logic              snooze,
  output logic              ring,
  output logic [IDX_W-1:0]  ring_slot,
  output logic              snoozing,
  output logic              end_ring,
  output logic [SLOTS-1:0]  armed,
  output state_t            state_dbg
);

  localparam int CNT_W = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

  state_t             state_q, state_d;
  logic [MIN_W-1:0]   prev_min;
  logic               prev_vld;
  logic               new_min;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [ALARM_W-1:0] cap_q, cap_d;
  logic [IDX_W-1:0]   slot_q, slot_d;
  logic [7:0]         ring_tmr_q, ring_tmr_d;
  logic [MIN_W-1:0]   snz_tmr_q, snz_tmr_d;
  logic [CNT_W-1:0]   snz_cnt_q, snz_cnt_d;
  logic               end_d;
  logic [ALARM_W-1:0] rd_time;
  logic               rd_arm;
  logic               match;
  logic               slot_hit;
  logic [SEC_W-1:0]   unused_sec;

  // Seconds are not needed: the ring timeout counts tick pulses instead
  assign unused_sec = time_in[SEC_LSB +: SEC_W];

  alarm_slot_bank #(.SLOTS(SLOTS), .IDX_W(IDX_W)) u_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr.wr_en),
    .wr_slot (wr.wr_slot),
    .wr_time (wr.wr_time),
    .wr_arm  (wr.wr_arm),
    .rd_idx  (idx_q),
    .rd_time (rd_time),
    .rd_arm  (rd_arm),
    .armed   (armed)
  );

  assign match    = rd_arm && (rd_time == cap_q);
  // Rewriting the slot that owns the session cancels the session
  assign slot_hit = wr.wr_en && (32'(wr.wr_slot) < SLOTS) && (wr.wr_slot == slot_q);
  // Any minute change counts, including a clockwork overwrite
  assign new_min  = prev_vld && (time_in[MIN_LSB +: MIN_W] != prev_min);

  // Minute tracker: the first clk after reset only loads the reference
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_min <= '0;
      prev_vld <= 1'b0;
    end else begin
      prev_min <= time_in[MIN_LSB +: MIN_W];
      prev_vld <= 1'b1;
    end
  end

  // Next-state and datapath decisions for scan and session handling
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cap_d      = cap_q;
    slot_d     = slot_q;
    ring_tmr_d = ring_tmr_q;
    snz_tmr_d  = snz_tmr_q;
    snz_cnt_d  = snz_cnt_q;
    end_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (new_min) begin
          state_d = ST_SCAN;
          idx_d   = '0;
          cap_d   = time_to_alarm(time_in);
        end
      end
      ST_SCAN: begin
        if (match) begin
          state_d    = ST_RING;
          slot_d     = idx_q;
          ring_tmr_d = '0;
          snz_cnt_d  = '0;
        end else if (32'(idx_q) == SLOTS - 1) begin
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_RING: begin
        // Dismiss outranks snooze; an exhausted snooze behaves as dismiss
        if (slot_hit || dismiss || (snooze && snz_cnt_q == CNT_W'(MAX_SNOOZE))) begin
          state_d = ST_IDLE;
          end_d   = 1'b1;
        end else if (snooze) begin
          state_d   = ST_SNOOZE;
          snz_cnt_d = snz_cnt_q + 1'b1;
          snz_tmr_d = '0;
        end else if (tick) begin
          if (ring_tmr_q == 8'(RING_SEC - 1)) begin
            state_d = ST_IDLE;
            end_d   = 1'b1;
          end else begin
            ring_tmr_d = ring_tmr_q + 1'b1;
          end
        end
      end
      ST_SNOOZE: begin
        if (slot_hit || dismiss) begin
          state_d = ST_IDLE;
          end_d   = 1'b1;
        end else if (new_min) begin
          if (snz_tmr_q == MIN_W'(SNOOZE_MIN - 1)) begin
            state_d    = ST_RING;
            ring_tmr_d = '0;
          end else begin
            snz_tmr_d = snz_tmr_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      cap_q      <= '0;
      slot_q     <= '0;
      ring_tmr_q <= '0;
      snz_tmr_q  <= '0;
      snz_cnt_q  <= '0;
      ring       <= 1'b0;
      snoozing   <= 1'b0;
      end_ring   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cap_q      <= cap_d;
      slot_q     <= slot_d;
      ring_tmr_q <= ring_tmr_d;
      snz_tmr_q  <= snz_tmr_d;
      snz_cnt_q  <= snz_cnt_d;
      ring       <= (state_d == ST_RING);
      snoozing   <= (state_d == ST_SNOOZE);
      end_ring   <= end_d;
    end
  end

  assign ring_slot = slot_q;
  assign state_dbg = state_q;

endmodule

// File: doc/alarm_scheduler.md
Name: alarm_scheduler

Overview:
- Multi-slot alarm controller for the digital clock; replaces the single-compare alarm path with SLOTS programmable alarms sharing one comparator.
- Watches the clockwork time bus; on every new minute, scans the armed slots sequentially and drives one ring session with snooze, dismiss and timeout handling.
- Sits beside the clockwork and date modules; driven by the board-level set FSM (write port) and the debounced buttons (dismiss/snooze).

Parameters:
SLOTS, 4, number of alarm slots (2..8)
SNOOZE_MIN, 5, minutes between snooze and re-ring (1..59)
MAX_SNOOZE, 3, snoozes allowed per session; further snooze acts as dismiss
RING_SEC, 60, seconds ringing without response before auto-stop (1..255)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
time_in  in  17  {hour[4:0],min[5:0],sec[5:0]} from clockwork
tick  in  1  one-clk pulse per second, synchronous to clk
wr_en  in  1  write slot (one-clk pulse)
wr_slot  in  $clog2(SLOTS)  slot index
wr_time  in  11  {hour[4:0],min[5:0]}
wr_arm  in  1  armed bit written with wr_time
dismiss  in  1  debounced pulse
snooze  in  1  debounced pulse
ring  out  1  high while ringing
ring_slot  out  $clog2(SLOTS)  slot that caused current session
snoozing  out  1  high in SNOOZE
end_ring  out  1  one-clk pulse when a session ends (any cause)
armed  out  SLOTS  armed bit per slot

Behaviour:
- Reset (rst low, async): all slots {00:00, disarmed}, armed=0, ring=0, snoozing=0, end_ring=0, ring_slot=0, state IDLE, snooze count 0, prev_min invalid.
- New-minute detect: prev_min register + valid flag. First clk after reset only loads prev_min. Thereafter new_min=1 for one clk when time_in[11:6] != prev_min (covers clockwork overwrite too).
- States: IDLE, SCAN, RING, SNOOZE.
- IDLE: new_min -> SCAN, index 0, capture {hour,min} of time_in.
- SCAN: one slot per clk; match = armed[i] & slot_time[i]=={captured hour,min}. First (lowest-index) match -> RING, ring_slot=i, ring_timer=0, snooze count=0. No match after slot SLOTS-1 -> IDLE. Scan takes at most SLOTS clks.
- RING: ring=1 registered (asserts the clk after entry). ring_timer increments on tick.
  - dismiss -> IDLE, end_ring pulse.
  - snooze with count<MAX_SNOOZE -> SNOOZE, count+1, snooze_timer=0.
  - snooze with count==MAX_SNOOZE -> treated as dismiss.
  - ring_timer reaching RING_SEC -> IDLE, end_ring.
  - dismiss and snooze same clk: dismiss wins.
- SNOOZE: ring=0, snoozing=1; snooze_timer increments on new_min; at SNOOZE_MIN -> RING (timer cleared, ring_slot kept). dismiss -> IDLE, end_ring. snooze ignored.
- New minutes in RING/SNOOZE do not trigger scans; coincident alarms during a session are dropped.
- Writes accepted in every state, take effect next clk. A write to ring_slot while in RING/SNOOZE ends the session: IDLE, end_ring. A write in SCAN to a not-yet-scanned slot is seen by the scan.
- wr_slot >= SLOTS ignored. Hours >23 or minutes >59 are stored as written and simply never match.
- end_ring never asserted together with ring.
- Reset mid-session: immediate return to reset values; no end_ring pulse.

Decomposition:
- Shared package/include: state encoding localparams, time-field widths (HOUR_W=5, MIN_W=6, SEC_W=6), alarm word width 11 and field slice positions (also used by clockwork/h24Toh12 users).
- One natural sub-module: alarm_slot_bank (SLOTS x 12-bit register file; write port, combinational read by index, armed vector out). The FSM, minute detector and timers stay in alarm_scheduler.

Test Plan:
- Slot1=07:30 armed; time steps 07:29->07:30 -> SCAN then RING within SLOTS+1 clks, ring_slot=1, ring=1; dismiss -> end_ring one clk, ring=0.
- Slots 0 and 2 both 06:00 armed -> ring_slot=0 only; slot 3 at 06:00 disarmed -> no ring when alone.
- Ringing 08:00, SNOOZE_MIN=5: snooze -> snoozing=1; re-ring at 08:05; snooze x3 then a 4th snooze -> end_ring, IDLE.
- No response, RING_SEC=60: 60 ticks -> ring=0, end_ring pulse; time passing 08:01 -> no re-ring.
- While ringing slot 2, write slot 2 -> end_ring next clk; write slot 1 instead -> ring continues.
- rst low mid-RING -> ring=0, armed=0 immediately; after release, first clk does not scan even if time_in matches old slot time.
